// File: rtl/diff_freq_pkg.sv
// Shared definitions for the per-channel serial pattern generator:
// FSM state encoding, default pattern length and command field widths.
package diff_freq_pkg;

  localparam int DATA_BIT_DEF = 32;
  localparam int SEL_W        = 4;
  localparam int PER_W        = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/diff_freq_serial_if.sv
// Command bus from the UART command decoder, fanned out to every channel.
// Handshake: cmd_tick_i is a one-cycle valid strobe with no ready/backpressure;
// all other fields are sampled only in the cycle cmd_tick_i is high and are
// don't-care otherwise. The decoder drives (master), each channel listens (slave).
interface diff_freq_serial_if #(
  parameter int DATA_BIT = diff_freq_pkg::DATA_BIT_DEF
);
  import diff_freq_pkg::*;

  logic                cmd_tick_i;
  logic [DATA_BIT-1:0] output_pattern_i;
  logic [DATA_BIT-1:0] freq_pattern_i;
  logic [SEL_W-1:0]    sel_out_i;
  logic                start_i;
  logic                stop_i;
  logic                mode_i;
  logic [PER_W-1:0]    slow_period_i;
  logic [PER_W-1:0]    fast_period_i;

  modport master (
    output cmd_tick_i, output_pattern_i, freq_pattern_i, sel_out_i,
           start_i, stop_i, mode_i, slow_period_i, fast_period_i
  );

  modport slave (
    input  cmd_tick_i, output_pattern_i, freq_pattern_i, sel_out_i,
           start_i, stop_i, mode_i, slow_period_i, fast_period_i
  );

endinterface

// File: rtl/diff_freq_serial_bit_timer.sv
// bit_timer: 8-bit loadable down-counter. expire_o is high while the count
// sits at zero, which marks the last hold cycle of the current bit.
module bit_timer
  import diff_freq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [PER_W-1:0] period_i,
  output logic             expire_o
);

  logic [PER_W-1:0] cnt_q;

  // Load on strobe, otherwise count down and rest at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= period_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/diff_freq_serial.sv
// diff_freq_serial: shifts a stored pattern out LSB-first on one pin, each bit
// held for a fast or slow period selected per bit. Commands are taken from the
// shared decoder bus when sel_out_i matches CH_ID.
// Optional feature macro DIFF_FREQ_SHADOW_EN: config-only commands received
// while running are parked in a shadow set and applied at the next pattern end.
module diff_freq_serial
  import diff_freq_pkg::*;
#(
  parameter int DATA_BIT = DATA_BIT_DEF,
  parameter int CH_ID    = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  diff_freq_serial_if.slave        cmd_if,
  output logic                     serial_o,
  output logic                     busy_o,
  output logic                     done_tick_o,
  output state_e                   state_o
);

  localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BIT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_BIT-1:0] pat_q, pat_d, freq_q, freq_d;
  logic                mode_q, mode_d;
  logic [PER_W-1:0]    slow_q, slow_d, fast_q, fast_d;
  logic                serial_q, serial_d;
  logic                done_q, done_d;
  logic                tmr_load;
  logic [PER_W-1:0]    tmr_period;
  logic                tmr_expire;
  logic                accept;

`ifdef DIFF_FREQ_SHADOW_EN
  logic [DATA_BIT-1:0] sh_pat_q, sh_pat_d, sh_freq_q, sh_freq_d;
  logic                sh_mode_q, sh_mode_d;
  logic [PER_W-1:0]    sh_slow_q, sh_slow_d, sh_fast_q, sh_fast_d;
  logic                pend_q, pend_d;
`endif

  assign accept = cmd_if.cmd_tick_i && (cmd_if.sel_out_i == SEL_W'(CH_ID));

  bit_timer u_bit_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (tmr_load),
    .period_i (tmr_period),
    .expire_o (tmr_expire)
  );

  // Next-state: command handling (stop > start > config) then bit stepping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    freq_d     = freq_q;
    mode_d     = mode_q;
    slow_d     = slow_q;
    fast_d     = fast_q;
    serial_d   = serial_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_period = slow_q;
`ifdef DIFF_FREQ_SHADOW_EN
    sh_pat_d   = sh_pat_q;
    sh_freq_d  = sh_freq_q;
    sh_mode_d  = sh_mode_q;
    sh_slow_d  = sh_slow_q;
    sh_fast_d  = sh_fast_q;
    pend_d     = pend_q;
`endif
    if (accept && cmd_if.stop_i) begin
      state_d  = S_IDLE;
      serial_d = 1'b0;
`ifdef DIFF_FREQ_SHADOW_EN
      pend_d   = 1'b0;
`endif
    end else if (accept && cmd_if.start_i) begin
      pat_d      = cmd_if.output_pattern_i;
      freq_d     = cmd_if.freq_pattern_i;
      mode_d     = cmd_if.mode_i;
      slow_d     = cmd_if.slow_period_i;
      fast_d     = cmd_if.fast_period_i;
      idx_d      = '0;
      state_d    = S_RUN;
      tmr_load   = 1'b1;
      tmr_period = cmd_if.freq_pattern_i[0] ? cmd_if.fast_period_i : cmd_if.slow_period_i;
      serial_d   = cmd_if.output_pattern_i[0];
`ifdef DIFF_FREQ_SHADOW_EN
      pend_d     = 1'b0;
`endif
    end else if (accept && (state_q == S_IDLE)) begin
      pat_d  = cmd_if.output_pattern_i;
      freq_d = cmd_if.freq_pattern_i;
      mode_d = cmd_if.mode_i;
      slow_d = cmd_if.slow_period_i;
      fast_d = cmd_if.fast_period_i;
    end else begin
`ifdef DIFF_FREQ_SHADOW_EN
      // Only reachable while running: park the config for the next pattern end.
      if (accept) begin
        sh_pat_d  = cmd_if.output_pattern_i;
        sh_freq_d = cmd_if.freq_pattern_i;
        sh_mode_d = cmd_if.mode_i;
        sh_slow_d = cmd_if.slow_period_i;
        sh_fast_d = cmd_if.fast_period_i;
        pend_d    = 1'b1;
      end
`endif
      if ((state_q == S_RUN) && tmr_expire) begin
        if (idx_q == IDX_LAST) begin
          done_d = 1'b1;
`ifdef DIFF_FREQ_SHADOW_EN
          if (pend_q) begin
            pat_d  = sh_pat_q;
            freq_d = sh_freq_q;
            mode_d = sh_mode_q;
            slow_d = sh_slow_q;
            fast_d = sh_fast_q;
            pend_d = accept;
          end
`endif
          // The finishing pass decides idle vs. wrap by the mode it ran with.
          if (!mode_q) begin
            state_d  = S_IDLE;
            serial_d = 1'b0;
          end else begin
            idx_d      = '0;
            tmr_load   = 1'b1;
            tmr_period = freq_d[0] ? fast_d : slow_d;
            serial_d   = pat_d[0];
          end
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          tmr_load   = 1'b1;
          tmr_period = freq_q[idx_d] ? fast_q : slow_q;
          serial_d   = pat_q[idx_d];
        end
      end
    end
  end

  // State, active config, index and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pat_q    <= '0;
      freq_q   <= '0;
      mode_q   <= 1'b0;
      slow_q   <= '0;
      fast_q   <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      freq_q   <= freq_d;
      mode_q   <= mode_d;
      slow_q   <= slow_d;
      fast_q   <= fast_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

`ifdef DIFF_FREQ_SHADOW_EN
  // Shadow config set and its pending flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_pat_q  <= '0;
      sh_freq_q <= '0;
      sh_mode_q <= 1'b0;
      sh_slow_q <= '0;
      sh_fast_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      sh_pat_q  <= sh_pat_d;
      sh_freq_q <= sh_freq_d;
      sh_mode_q <= sh_mode_d;
      sh_slow_q <= sh_slow_d;
      sh_fast_q <= sh_fast_d;
      pend_q    <= pend_d;
    end
  end
`endif

  assign serial_o    = serial_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_tick_o = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_diff_freq_serial.sv
// Directed testbench for diff_freq_serial (DATA_BIT=32, CH_ID=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_diff_freq_serial;
  import diff_freq_pkg::*;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  diff_freq_serial_if #(.DATA_BIT(DW)) cmd_if ();

  logic   serial, busy, done;
  state_e state;

  diff_freq_serial #(.DATA_BIT(DW), .CH_ID(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_if      (cmd_if),
    .serial_o    (serial),
    .busy_o      (busy),
    .done_tick_o (done),
    .state_o     (state)
  );

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];   // {busy, serial} per cycle

  // ---------------- driver tasks ----------------
  task automatic clear_cmd();
    cmd_if.cmd_tick_i       = 1'b0;
    cmd_if.output_pattern_i = '0;
    cmd_if.freq_pattern_i   = '0;
    cmd_if.sel_out_i        = '0;
    cmd_if.start_i          = 1'b0;
    cmd_if.stop_i           = 1'b0;
    cmd_if.mode_i           = 1'b0;
    cmd_if.slow_period_i    = '0;
    cmd_if.fast_period_i    = '0;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_cmd(input logic [3:0] sel, input logic start, input logic stop,
                          input logic mode, input logic [DW-1:0] pat,
                          input logic [DW-1:0] freq, input logic [7:0] slow,
                          input logic [7:0] fast);
    cmd_if.cmd_tick_i       = 1'b1;
    cmd_if.sel_out_i        = sel;
    cmd_if.start_i          = start;
    cmd_if.stop_i           = stop;
    cmd_if.mode_i           = mode;
    cmd_if.output_pattern_i = pat;
    cmd_if.freq_pattern_i   = freq;
    cmd_if.slow_period_i    = slow;
    cmd_if.fast_period_i    = fast;
    @(negedge clk);
    clear_cmd();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_cmd();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({serial, busy, done} !== 3'b000 || state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_held: serial/busy/done=%b%b%b state=%0d, need 000 state=0", serial, busy, done, state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({serial, busy, done} !== 3'b000 || state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_release: serial/busy/done=%b%b%b state=%0d, need 000 state=0", serial, busy, done, state);
    end
  endtask

  task automatic test_select();
    send_cmd(4'd3, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || serial !== 1'b0) begin
        errors++;
        $display("FAIL select_other cyc %0d: busy=%b serial=%b, need 0 0", i, busy, serial);
      end
      @(negedge clk);
    end
    send_cmd(4'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 8'd0, 8'd0);
    checks++;
    if (busy !== 1'b1 || serial !== 1'b1) begin
      errors++;
      $display("FAIL select_own: busy=%b serial=%b, need 1 1", busy, serial);
    end
    send_cmd(4'd2, 1'b0, 1'b1, 1'b0, '0, '0, 8'd0, 8'd0);
    checks++;
    if (busy !== 1'b0 || serial !== 1'b0) begin
      errors++;
      $display("FAIL select_stop: busy=%b serial=%b, need 0 0", busy, serial);
    end
  endtask

  task automatic test_one_shot();
    logic [DW-1:0] pat, freq;
    logic [1:0] e;
    int n;
    pat  = 32'h0000_0005;
    freq = 32'h0000_0001;
    for (int b = 0; b < DW; b++)
      repeat (freq[b] ? 1 : 4) exp_q.push_back({1'b1, pat[b]});
    send_cmd(4'd2, 1'b1, 1'b0, 1'b0, pat, freq, 8'd3, 8'd0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, serial} !== e || done !== 1'b0) begin
        errors++;
        $display("FAIL one_shot cyc %0d: busy,serial=%b done=%b, need %b done=0", n, {busy, serial}, done, e);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || serial !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_end: done=%b busy=%b serial=%b, need 1 0 0", done, busy, serial);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_after: done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] pat;
    logic exp_done;
    pat = 32'hA5C3_0F96;
    send_cmd(4'd2, 1'b1, 1'b0, 1'b1, pat, 32'h1234_5678, 8'd0, 8'd0);
    for (int i = 0; i <= 3 * DW; i++) begin
      exp_done = (i > 0) && (i % DW == 0);
      checks++;
      if (serial !== pat[i % DW] || busy !== 1'b1 || done !== exp_done) begin
        errors++;
        $display("FAIL continuous cyc %0d: serial=%b busy=%b done=%b, need %b 1 %b", i, serial, busy, done, pat[i % DW], exp_done);
      end
      @(negedge clk);
    end
    send_cmd(4'd2, 1'b0, 1'b1, 1'b0, '0, '0, 8'd0, 8'd0);
  endtask

  task automatic test_stop();
    send_cmd(4'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 8'd0, 8'd0);
    repeat (10) @(negedge clk);
    checks++;
    if (serial !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre: serial=%b busy=%b, need 1 1", serial, busy);
    end
    send_cmd(4'd2, 1'b0, 1'b1, 1'b0, '0, '0, 8'd0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (serial !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL stop_mid cyc %0d: serial=%b busy=%b done=%b, need 0 0 0", i, serial, busy, done);
      end
      @(negedge clk);
    end
    send_cmd(4'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (serial !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL start_stop cyc %0d: serial=%b busy=%b, need 0 0", i, serial, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_restart_at_end();
    logic [DW-1:0] p2;
    p2 = 32'h0000_0003;
    send_cmd(4'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, 8'd0, 8'd0);
    repeat (DW - 1) @(negedge clk);
    checks++;
    if (serial !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_last_bit: serial=%b busy=%b, need 1 1", serial, busy);
    end
    send_cmd(4'd2, 1'b1, 1'b0, 1'b0, p2, 32'h0, 8'd0, 8'd0);
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (serial !== p2[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL restart cyc %0d: serial=%b busy=%b done=%b, need %b 1 0", i, serial, busy, done, p2[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_end: done=%b busy=%b, need 1 0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_shadow();
    logic [DW-1:0] pa, pb;
    logic exp_s;
    pa = 32'h0F0F_00FF;
    pb = 32'h3333_CCCC;
    send_cmd(4'd2, 1'b1, 1'b0, 1'b1, pa, 32'h0, 8'd0, 8'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (serial !== pa[5]) begin
      errors++;
      $display("FAIL shadow_bit5: serial=%b, need %b", serial, pa[5]);
    end
    send_cmd(4'd2, 1'b0, 1'b0, 1'b1, pb, 32'h0, 8'd0, 8'd0);
    for (int k = 6; k < 6 + 3 * DW; k++) begin
`ifdef DIFF_FREQ_SHADOW_EN
      exp_s = (k < DW) ? pa[k] : pb[k % DW];
`else
      exp_s = pa[k % DW];
`endif
      checks++;
      if (serial !== exp_s || busy !== 1'b1) begin
        errors++;
        $display("FAIL shadow bit %0d: serial=%b busy=%b, need %b 1", k, serial, busy, exp_s);
      end
      @(negedge clk);
    end
    send_cmd(4'd2, 1'b0, 1'b1, 1'b0, '0, '0, 8'd0, 8'd0);
  endtask

  task automatic test_reset_mid();
    send_cmd(4'd2, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 8'd3, 8'd3);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({serial, busy, done} !== 3'b000 || state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_async: serial/busy/done=%b%b%b state=%0d, need 000 state=0", serial, busy, done, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (serial !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_after cyc %0d: serial=%b busy=%b, need 0 0", i, serial, busy);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    clear_cmd();
    @(negedge clk);
    test_reset();
    test_select();
    test_one_shot();
    test_continuous();
    test_stop();
    test_restart_at_end();
    test_shadow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
